ddr_req_arbiter: RTL

DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

---
 rtl/ddr_req_arbiter_if.sv | 36 +++
 rtl/ddr_req_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ddr_req_arbiter_if.sv
// Handshake bundle between the traffic generator / DDR controller and the
// request arbiter. The arbiter connects through the slave modport; the
// environment (generator plus controller model) uses the master modport.
interface ddr_req_arbiter_if #(
  parameter int ADDR_W = 27
);
  // Traffic-generator side
  logic              enable;
  logic              write_req;
  logic              read_req;
  logic              write_allowed;
  logic              read_allowed;
  logic              writes_pending;
  logic              reads_pending;
  // Memory-controller side
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;

  modport slave (
    input  enable, write_req, read_req, app_rdy, app_wdf_rdy, app_rd_data_valid,
    output write_allowed, read_allowed, writes_pending, reads_pending,
           app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end
  );

  modport master (
    output enable, write_req, read_req, app_rdy, app_wdf_rdy, app_rd_data_valid,
    input  write_allowed, read_allowed, writes_pending, reads_pending,
           app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/ddr_req_arbiter.sv
// DDR request arbiter: accepts single-cycle write/read requests, issues one
// command at a time to the memory controller, round-robins simultaneous
// requests and limits the number of reads awaiting data.
// Optional build macro ARB_STATS_EN adds saturating accepted-command counters
// (wr_cmd_count / rd_cmd_count).
module ddr_req_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_W          = 27
) (
  input  logic               clk,
  input  logic               resetn,
  ddr_req_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        wr_cmd_count,
  output logic [15:0]        rd_cmd_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam logic [2:0] CMD_WR  = 3'b000;
  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(8);

  state_t            state_q;
  logic              app_en_q;
  logic              wdf_q;
  logic [2:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              last_wr_q;   // 1: last grant was a write, 0: a read
  logic [3:0]        rd_cnt_q;
  logic [3:0]        rd_cnt_d;

  logic is_idle, wr_ok, rd_ok, wr_acc, rd_acc, grant_wr, grant_rd;
  logic wr_cmd_acc, wr_dat_acc, rd_cmd_acc, wr_done;

  // Grant qualification, round-robin tie break and controller handshakes.
  // The allow outputs are gated by resetn so they read 0 while reset is held.
  always_comb begin
    is_idle    = (state_q == IDLE) && resetn;
    wr_ok      = is_idle && bus.enable;
    rd_ok      = wr_ok && (rd_cnt_q < MAX_OUT);
    wr_acc     = bus.write_req && wr_ok;
    rd_acc     = bus.read_req && rd_ok;
    grant_wr   = wr_acc && (!rd_acc || !last_wr_q);
    grant_rd   = rd_acc && (!wr_acc || last_wr_q);
    wr_cmd_acc = (state_q == WR) && app_en_q && bus.app_rdy;
    wr_dat_acc = (state_q == WR) && wdf_q && bus.app_wdf_rdy;
    rd_cmd_acc = (state_q == RD) && app_en_q && bus.app_rdy;
    // Write finishes once both command and data have been taken, in any order.
    wr_done    = (!app_en_q || bus.app_rdy) && (!wdf_q || bus.app_wdf_rdy);
  end

  // Command FSM with registered controller outputs and address counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      app_en_q  <= 1'b0;
      wdf_q     <= 1'b0;
      cmd_q     <= CMD_WR;
      addr_q    <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      last_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            state_q   <= WR;
            app_en_q  <= 1'b1;
            wdf_q     <= 1'b1;
            cmd_q     <= CMD_WR;
            addr_q    <= wr_addr_q;
            last_wr_q <= 1'b1;
          end else if (grant_rd) begin
            state_q   <= RD;
            app_en_q  <= 1'b1;
            cmd_q     <= CMD_RD;
            addr_q    <= rd_addr_q;
            last_wr_q <= 1'b0;
          end
        end
        WR: begin
          if (wr_cmd_acc) begin
            app_en_q  <= 1'b0;
            wr_addr_q <= wr_addr_q + ADDR_STEP;
          end
          if (wr_dat_acc) begin
            wdf_q <= 1'b0;
          end
          if (wr_done) begin
            state_q <= IDLE;
            cmd_q   <= CMD_WR;
            addr_q  <= '0;
          end
        end
        RD: begin
          if (rd_cmd_acc) begin
            state_q   <= IDLE;
            app_en_q  <= 1'b0;
            cmd_q     <= CMD_WR;
            addr_q    <= '0;
            rd_addr_q <= rd_addr_q + ADDR_STEP;
          end
        end
        default: begin
          state_q  <= IDLE;
          app_en_q <= 1'b0;
          wdf_q    <= 1'b0;
          cmd_q    <= CMD_WR;
          addr_q   <= '0;
        end
      endcase
    end
  end

  // Outstanding-read count: +1 on read command accept, -1 on returned data;
  // a data pulse with nothing outstanding is ignored.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (rd_cmd_acc && !(bus.app_rd_data_valid && rd_cnt_q != 4'd0)) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
    end else if (!rd_cmd_acc && bus.app_rd_data_valid && rd_cnt_q != 4'd0) begin
      rd_cnt_d = rd_cnt_q - 4'd1;
    end
  end

  // Outstanding-read count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= 4'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign bus.write_allowed  = wr_ok;
  assign bus.read_allowed   = rd_ok;
  assign bus.writes_pending = (state_q == WR);
  assign bus.reads_pending  = (rd_cnt_q != 4'd0);
  assign bus.app_en         = app_en_q;
  assign bus.app_cmd        = cmd_q;
  assign bus.app_addr       = addr_q;
  assign bus.app_wdf_wren   = wdf_q;
  assign bus.app_wdf_end    = wdf_q;

`ifdef ARB_STATS_EN
  logic [15:0] wr_stat_q;
  logic [15:0] rd_stat_q;

  // Saturating counts of controller-accepted write and read commands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_stat_q <= 16'd0;
      rd_stat_q <= 16'd0;
    end else begin
      if (wr_cmd_acc && wr_stat_q != 16'hFFFF) begin
        wr_stat_q <= wr_stat_q + 16'd1;
      end
      if (rd_cmd_acc && rd_stat_q != 16'hFFFF) begin
        rd_stat_q <= rd_stat_q + 16'd1;
      end
    end
  end

  assign wr_cmd_count = wr_stat_q;
  assign rd_cmd_count = rd_stat_q;
`endif

endmodule
